// File: rtl/csr_trap_seq_pkg.sv
`default_nettype none
// ============================================================================
// csr_trap_seq_pkg : shared constants and state type for the trap sequencer
// Rev 1.0
// ============================================================================
package csr_trap_seq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int          CAUSE_W          = 4;
    localparam logic [3:0]  CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0]  CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0]  CAUSE_ECALL_M    = 4'd11;

    localparam int          MSTATUS_MIE    = 3;
    localparam int          MSTATUS_MPIE   = 7;
    localparam int          MSTATUS_MPP_LO = 11;
    localparam int          MSTATUS_MPP_HI = 12;

    localparam logic [1:0]  CTR_NONE = 2'b00;
    localparam logic [1:0]  CTR_W1   = 2'b10;
    localparam logic [1:0]  CTR_W12  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_T_SAVE = 3'd1,
        S_T_STAT = 3'd2,
        S_T_VEC  = 3'd3,
        S_R_STAT = 3'd4,
        S_R_PC   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/csr_trap_mstatus_upd.sv
`default_nettype none
// ============================================================================
// csr_trap_mstatus_upd : new mstatus value for trap entry or mret
// Rev 1.0
// ============================================================================
module csr_trap_mstatus_upd
    import csr_trap_seq_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic        is_ret,
    output logic [31:0] mstatus_new
);

    always_comb begin
        mstatus_new = rdata;
        if (is_ret) begin
            mstatus_new[MSTATUS_MIE]  = rdata[MSTATUS_MPIE];
            mstatus_new[MSTATUS_MPIE] = 1'b1;
        end else begin
            mstatus_new[MSTATUS_MPIE] = rdata[MSTATUS_MIE];
            mstatus_new[MSTATUS_MIE]  = 1'b0;
        end
        // M-only hart: previous privilege is always machine mode
        mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule
`default_nettype wire

// File: rtl/csr_trap_seq.sv
`default_nettype none
// ============================================================================
// csr_trap_seq : multi-cycle trap entry / mret sequencer driving the CSR file
// Rev 1.0
// ============================================================================
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter logic [11:0] ADDR_MSTATUS = CSR_MSTATUS,
    parameter logic [11:0] ADDR_MTVEC   = CSR_MTVEC,
    parameter logic [11:0] ADDR_MEPC    = CSR_MEPC,
    parameter logic [11:0] ADDR_MCAUSE  = CSR_MCAUSE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt_valid,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        illegal,
    input  logic        mret,
    input  logic [31:0] pc_cur,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr1,
    output logic [31:0] csr_wdata1,
    output logic [11:0] csr_waddr2,
    output logic [31:0] csr_wdata2,
    output logic [1:0]  csr_ctr,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] pc_redirect
);

    state_t               state, state_nxt;
    logic [31:0]          pc_lat;
    logic [CAUSE_W-1:0]   cause_lat;
    logic [CAUSE_W-1:0]   cause_sel;
    logic                 trap_take;
    logic [31:0]          mstatus_new;
    logic                 unused_bits;

    // pc low bits are discarded when written to mepc
    assign unused_bits = ^pc_lat[1:0];

    csr_trap_mstatus_upd u_mstatus_upd (
        .rdata       (csr_rdata),
        .is_ret      (state == S_R_STAT),
        .mstatus_new (mstatus_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc_lat    <= 32'd0;
            cause_lat <= '0;
        end else begin
            state <= state_nxt;
            if (trap_take) begin
                pc_lat    <= pc_cur;
                cause_lat <= cause_sel;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        trap_take      = 1'b0;
        cause_sel      = '0;
        csr_raddr      = 12'd0;
        csr_waddr1     = 12'd0;
        csr_wdata1     = 32'd0;
        csr_waddr2     = 12'd0;
        csr_wdata2     = 32'd0;
        csr_ctr        = CTR_NONE;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        pc_redirect    = 32'd0;

        case (state)
            S_IDLE: begin
                // rst gating keeps every output quiet while reset is held
                if (!rst && evt_valid) begin
                    if (illegal) begin
                        trap_take = 1'b1;
                        cause_sel = CAUSE_ILLEGAL;
                    end else if (ecall) begin
                        trap_take = 1'b1;
                        cause_sel = CAUSE_ECALL_M;
                    end else if (ebreak) begin
                        trap_take = 1'b1;
                        cause_sel = CAUSE_BREAKPOINT;
                    end
                    if (trap_take) begin
                        state_nxt = S_T_SAVE;
                        stall     = 1'b1;
                    end else if (mret) begin
                        state_nxt = S_R_STAT;
                        stall     = 1'b1;
                    end
                end
            end
            S_T_SAVE: begin
                stall      = 1'b1;
                csr_ctr    = CTR_W12;
                csr_waddr1 = ADDR_MEPC;
                csr_wdata1 = {pc_lat[31:2], 2'b00};
                csr_waddr2 = ADDR_MCAUSE;
                csr_wdata2 = {{(32-CAUSE_W){1'b0}}, cause_lat};
                state_nxt  = S_T_STAT;
            end
            S_T_STAT: begin
                stall      = 1'b1;
                csr_raddr  = ADDR_MSTATUS;
                csr_ctr    = CTR_W1;
                csr_waddr1 = ADDR_MSTATUS;
                csr_wdata1 = mstatus_new;
                state_nxt  = S_T_VEC;
            end
            S_T_VEC: begin
                // vectored mode is ignored: exceptions always land on the base
                stall          = 1'b1;
                csr_raddr      = ADDR_MTVEC;
                redirect_valid = 1'b1;
                pc_redirect    = {csr_rdata[31:2], 2'b00};
                state_nxt      = S_IDLE;
            end
            S_R_STAT: begin
                stall      = 1'b1;
                csr_raddr  = ADDR_MSTATUS;
                csr_ctr    = CTR_W1;
                csr_waddr1 = ADDR_MSTATUS;
                csr_wdata1 = mstatus_new;
                state_nxt  = S_R_PC;
            end
            S_R_PC: begin
                stall          = 1'b1;
                csr_raddr      = ADDR_MEPC;
                redirect_valid = 1'b1;
                pc_redirect    = {csr_rdata[31:2], 2'b00};
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_seq.sv
`default_nettype none
// ============================================================================
// tb_csr_trap_seq : table-driven bench with a CSR-file model and write scoreboard
// Rev 1.0
// ============================================================================
module tb_csr_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        evt_valid, ecall, ebreak, illegal, mret;
    logic [31:0] pc_cur;
    logic [11:0] csr_raddr, csr_waddr1, csr_waddr2;
    logic [31:0] csr_rdata, csr_wdata1, csr_wdata2;
    logic [1:0]  csr_ctr;
    logic        stall, redirect_valid;
    logic [31:0] pc_redirect;

    always #5 clk = ~clk;

    csr_trap_seq dut (
        .clk            (clk),
        .rst            (rst),
        .evt_valid      (evt_valid),
        .ecall          (ecall),
        .ebreak         (ebreak),
        .illegal        (illegal),
        .mret           (mret),
        .pc_cur         (pc_cur),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_waddr1     (csr_waddr1),
        .csr_wdata1     (csr_wdata1),
        .csr_waddr2     (csr_waddr2),
        .csr_wdata2     (csr_wdata2),
        .csr_ctr        (csr_ctr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .pc_redirect    (pc_redirect)
    );

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    // {evt_valid, illegal, ecall, ebreak, mret}
    localparam logic [4:0] EV_NONE    = 5'b00000;
    localparam logic [4:0] EV_ECALL   = 5'b10100;
    localparam logic [4:0] EV_EBREAK  = 5'b10010;
    localparam logic [4:0] EV_MRET    = 5'b10001;
    localparam logic [4:0] EV_ALL3    = 5'b11101;
    localparam logic [4:0] EV_EBRMRET = 5'b10011;
    localparam logic [4:0] EV_NOVAL   = 5'b00100;

    // CSR file model: combinational read, writes land at the clock edge
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic        pre_en;
    logic [31:0] pre_mstatus, pre_mtvec, pre_mepc, pre_mcause;

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            A_MSTATUS: csr_rdata = m_mstatus;
            A_MTVEC:   csr_rdata = m_mtvec;
            A_MEPC:    csr_rdata = m_mepc;
            A_MCAUSE:  csr_rdata = m_mcause;
            default:   csr_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (pre_en) begin
            m_mstatus <= pre_mstatus;
            m_mtvec   <= pre_mtvec;
            m_mepc    <= pre_mepc;
            m_mcause  <= pre_mcause;
        end else begin
            if (csr_ctr[1]) begin
                case (csr_waddr1)
                    A_MSTATUS: m_mstatus <= csr_wdata1;
                    A_MTVEC:   m_mtvec   <= csr_wdata1;
                    A_MEPC:    m_mepc    <= csr_wdata1;
                    A_MCAUSE:  m_mcause  <= csr_wdata1;
                    default: ;
                endcase
            end
            if (csr_ctr == 2'b11) begin
                case (csr_waddr2)
                    A_MSTATUS: m_mstatus <= csr_wdata2;
                    A_MTVEC:   m_mtvec   <= csr_wdata2;
                    A_MEPC:    m_mepc    <= csr_wdata2;
                    A_MCAUSE:  m_mcause  <= csr_wdata2;
                    default: ;
                endcase
            end
        end
    end

    typedef struct {
        logic [1:0]  kind;   // 0 write port1, 1 write port2, 2 redirect
        logic [11:0] addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [4:0]  ev;
        logic [31:0] pc;
        logic [31:0] ms0;
        logic [31:0] mtvec;
        logic [31:0] mepc0;
        logic        trap;
        logic [31:0] exp_mepc;
        logic [31:0] exp_cause;
        logic [31:0] exp_ms;
        logic [31:0] exp_tgt;
        int          stalls;
        int          redir;
    } vec_t;

    sb_t         sb_q[$];
    logic [4:0]  stim_q[$];
    logic [1:0]  ctr_hist[$];
    vec_t        vecs[7];
    int          n_pass = 0;
    int          n_total = 0;
    int          stall_cnt, redir_cyc, mcause_wr;
    logic [31:0] last_tgt;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic void sb_cmp(input logic [1:0] kind, input logic [11:0] addr, input logic [31:0] data);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got kind %0d addr %h data %h expected nothing", kind, addr, data);
            return;
        end
        e = sb_q.pop_front();
        chk("sb_kind", {30'd0, kind}, {30'd0, e.kind});
        if (e.kind != 2'd2) chk("sb_addr", {20'd0, addr}, {20'd0, e.addr});
        chk("sb_data", data, e.data);
    endfunction

    task automatic push_trap(input logic [31:0] mepc_v, input logic [31:0] cause_v,
                             input logic [31:0] ms_v, input logic [31:0] tgt);
        sb_q.push_back('{2'd0, A_MEPC, mepc_v});
        sb_q.push_back('{2'd1, A_MCAUSE, cause_v});
        sb_q.push_back('{2'd0, A_MSTATUS, ms_v});
        sb_q.push_back('{2'd2, 12'd0, tgt});
    endtask

    task automatic push_ret(input logic [31:0] ms_v, input logic [31:0] tgt);
        sb_q.push_back('{2'd0, A_MSTATUS, ms_v});
        sb_q.push_back('{2'd2, 12'd0, tgt});
    endtask

    task automatic preload(input logic [31:0] ms, input logic [31:0] tv,
                           input logic [31:0] ep, input logic [31:0] mc);
        pre_mstatus = ms; pre_mtvec = tv; pre_mepc = ep; pre_mcause = mc;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Called at a falling edge; drives one stimulus per cycle and checks outputs
    task automatic run_cycles(input int n);
        logic [4:0] ev;
        stall_cnt = 0; redir_cyc = -1; mcause_wr = 0; last_tgt = 32'd0;
        ctr_hist.delete();
        for (int c = 0; c < n; c++) begin
            ev = (stim_q.size() > 0) ? stim_q.pop_front() : EV_NONE;
            {evt_valid, illegal, ecall, ebreak, mret} = ev;
            #1;
            ctr_hist.push_back(csr_ctr);
            if (stall) stall_cnt++;
            if (csr_ctr[1]) sb_cmp(2'd0, csr_waddr1, csr_wdata1);
            else chk("p1_idle_zero", {csr_waddr1, 20'd0} | csr_wdata1, 32'd0);
            if (csr_ctr == 2'b11) begin
                sb_cmp(2'd1, csr_waddr2, csr_wdata2);
                if (csr_waddr2 == A_MCAUSE) mcause_wr++;
            end else chk("p2_idle_zero", {csr_waddr2, 20'd0} | csr_wdata2, 32'd0);
            if (redirect_valid) begin
                redir_cyc = c;
                last_tgt  = pc_redirect;
                sb_cmp(2'd2, 12'd0, pc_redirect);
            end
            @(negedge clk);
        end
        {evt_valid, illegal, ecall, ebreak, mret} = EV_NONE;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        preload(v.ms0, v.mtvec, v.mepc0, 32'hDEAD_0000);
        pc_cur = v.pc;
        if (v.trap) push_trap(v.exp_mepc, v.exp_cause, v.exp_ms, v.exp_tgt);
        else        push_ret(v.exp_ms, v.exp_tgt);
        stim_q = {v.ev};
        run_cycles(v.stalls + 1);
        chk($sformatf("v%0d_stalls", i), stall_cnt, v.stalls);
        chk($sformatf("v%0d_redir_cycle", i), redir_cyc, v.redir);
        chk($sformatf("v%0d_mstatus", i), m_mstatus, v.exp_ms);
        chk($sformatf("v%0d_mepc", i), m_mepc, v.exp_mepc);
        chk($sformatf("v%0d_mcause", i), m_mcause, v.exp_cause);
        chk($sformatf("v%0d_sb_drained", i), sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        //           ev          pc            ms0           mtvec         mepc0         trap  exp_mepc      exp_cause     exp_ms        exp_tgt       st rd
        vecs[0] = '{EV_ECALL,   32'h80000010, 32'h00000008, 32'h80001001, 32'h00000000, 1'b1, 32'h80000010, 32'd11,       32'h00001880, 32'h80001000, 4, 3};
        vecs[1] = '{EV_MRET,    32'h00000000, 32'h00001880, 32'h00000000, 32'h80000014, 1'b0, 32'h80000014, 32'hDEAD0000, 32'h00001888, 32'h80000014, 3, 2};
        vecs[2] = '{EV_ALL3,    32'h00000103, 32'h00000000, 32'h00000200, 32'h00000000, 1'b1, 32'h00000100, 32'd2,        32'h00001800, 32'h00000200, 4, 3};
        vecs[3] = '{EV_EBREAK,  32'h12345678, 32'hFFFFFFFF, 32'hABCDEF03, 32'h00000000, 1'b1, 32'h12345678, 32'd3,        32'hFFFFFFF7, 32'hABCDEF00, 4, 3};
        vecs[4] = '{EV_MRET,    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000007, 1'b0, 32'h00000007, 32'hDEAD0000, 32'h00001880, 32'h00000004, 3, 2};
        vecs[5] = '{EV_MRET,    32'h00000000, 32'hFFFFFF77, 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 32'hDEAD0000, 32'hFFFFFFF7, 32'h80000000, 3, 2};
        vecs[6] = '{EV_EBRMRET, 32'h00000044, 32'h00000080, 32'h00000100, 32'h00000000, 1'b1, 32'h00000044, 32'd3,        32'h00001800, 32'h00000100, 4, 3};

        pre_en = 1'b0;
        pre_mstatus = 0; pre_mtvec = 0; pre_mepc = 0; pre_mcause = 0;
        pc_cur = 32'h80000010;
        rst = 1'b1;
        {evt_valid, illegal, ecall, ebreak, mret} = EV_ECALL;
        @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ctr", {30'd0, csr_ctr}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_raddr", {20'd0, csr_raddr}, 32'd0);
        @(negedge clk);
        {evt_valid, illegal, ecall, ebreak, mret} = EV_NONE;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // ecall without evt_valid: nothing happens
        preload(32'h8, 32'h100, 32'h0, 32'h0);
        stim_q = {EV_NOVAL, EV_NOVAL, EV_NOVAL};
        run_cycles(3);
        chk("noval_stalls", stall_cnt, 0);
        chk("noval_mcause", m_mcause, 32'h0);

        // ecall re-asserted during T_SAVE is ignored
        preload(32'h8, 32'h80001001, 32'h0, 32'h0);
        pc_cur = 32'h80000020;
        push_trap(32'h80000020, 32'd11, 32'h00001880, 32'h80001000);
        stim_q = {EV_ECALL, EV_ECALL};
        run_cycles(6);
        chk("hold_stalls", stall_cnt, 4);
        chk("hold_mcause_writes", mcause_wr, 1);
        chk("hold_sb_drained", sb_q.size(), 0);
        sb_q.delete();

        // back-to-back ecall then mret in the first idle cycle
        preload(32'h8, 32'h80001001, 32'h0, 32'h0);
        pc_cur = 32'h80000010;
        push_trap(32'h80000010, 32'd11, 32'h00001880, 32'h80001000);
        push_ret(32'h00001888, 32'h80000010);
        stim_q = {EV_ECALL, EV_NONE, EV_NONE, EV_NONE, EV_MRET};
        run_cycles(8);
        chk("b2b_stalls", stall_cnt, 7);
        chk("b2b_final_pc", last_tgt, 32'h80000010);
        chk("b2b_ctr_pattern", {22'd0, ctr_hist[1], ctr_hist[2], ctr_hist[3], ctr_hist[5], ctr_hist[6]},
            {22'd0, 10'b11_10_00_10_00});
        chk("b2b_ctr_accept", {30'd0, ctr_hist[4]}, 32'd0);
        chk("b2b_sb_drained", sb_q.size(), 0);
        sb_q.delete();

        // asynchronous reset asserted mid-T_STAT
        preload(32'h8, 32'h80001001, 32'h0, 32'h0);
        push_trap(32'h80000010, 32'd11, 32'h0, 32'h0);
        stim_q = {EV_ECALL};
        run_cycles(2);
        #1;
        chk("tstat_ctr", {30'd0, csr_ctr}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_ctr", {30'd0, csr_ctr}, 32'd0);
        chk("arst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("arst_raddr", {20'd0, csr_raddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_mstatus_kept", m_mstatus, 32'h8);
        chk("arst_mcause_saved", m_mcause, 32'd11);
        sb_q.delete();
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish before 50000");
        $fatal(1);
    end

endmodule
`default_nettype wire
